// File: rtl/opentdc_event_fifo.sv
// Timestamp FIFO between the TDC capture logic and the wishbone register bank.
// First-word-fall-through; events arriving while full are dropped and counted.
module opentdc_event_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 32,
  parameter int unsigned FW    = 16,
  parameter int unsigned OVW   = 8
) (
  input  logic                     wb_clk_i,
  input  logic                     rst_n_i,
  input  logic                     evt_valid_i,
  input  logic [CW-1:0]            evt_coarse_i,
  input  logic [FW-1:0]            evt_fine_i,
  input  logic                     rd_i,
  input  logic                     clr_i,
  output logic                     rd_valid_o,
  output logic [CW+FW-1:0]         rd_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic [OVW-1:0]           ovf_cnt_o,
  output logic                     ovf_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned DW = CW + FW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [DW-1:0]  mem_q [DEPTH];

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    level_q, level_d;
  logic [OVW-1:0] ovf_cnt_q, ovf_cnt_d;
  logic           ovf_q, ovf_d;

  logic           is_full, is_empty;
  logic           pop, push, drop;
  logic [DW-1:0]  wr_data;

  always_comb begin
    is_full  = (level_q == DEPTH_L);
    is_empty = (level_q == '0);
    wr_data  = {evt_coarse_i, evt_fine_i};

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push alongside it.
    pop  = rd_i && !is_empty && !clr_i;
    push = evt_valid_i && (!is_full || pop) && !clr_i;
    drop = evt_valid_i && is_full && !pop && !clr_i;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_cnt_d = ovf_cnt_q;
    ovf_d     = ovf_q;

    if (clr_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      level_d   = '0;
      ovf_cnt_d = '0;
      ovf_d     = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   level_d = level_q + (AW+1)'(1);
        2'b01:   level_d = level_q - (AW+1)'(1);
        default: level_d = level_q;
      endcase
      if (drop) begin
        ovf_d = 1'b1;
        if (ovf_cnt_q != '1) begin
          ovf_cnt_d = ovf_cnt_q + OVW'(1);
        end
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_cnt_q <= ovf_cnt_d;
      ovf_q     <= ovf_d;
    end
  end

  // Storage is deliberately not reset; only pointers and counters are.
  always_ff @(posedge wb_clk_i) begin
    if (rst_n_i && push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    rd_valid_o = !is_empty;
    full_o     = is_full;
    level_o    = level_q;
    ovf_cnt_o  = ovf_cnt_q;
    ovf_o      = ovf_q;
    rd_data_o  = is_empty ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: tb/tb_opentdc_event_fifo.sv
// Scoreboard bench for opentdc_event_fifo: a queue model tracks accepted events,
// drops and clears; every cycle the DUT outputs are compared against it.
module tb_opentdc_event_fifo;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 32;
  localparam int unsigned FW    = 16;
  localparam int unsigned OVW   = 8;
  localparam int unsigned DW    = CW + FW;

  logic                   wb_clk_i = 1'b0;
  logic                   rst_n_i = 1'b0;
  logic                   evt_valid_i = 1'b0;
  logic [CW-1:0]          evt_coarse_i = '0;
  logic [FW-1:0]          evt_fine_i = '0;
  logic                   rd_i = 1'b0;
  logic                   clr_i = 1'b0;
  logic                   rd_valid_o;
  logic [DW-1:0]          rd_data_o;
  logic [$clog2(DEPTH):0] level_o;
  logic                   full_o;
  logic [OVW-1:0]         ovf_cnt_o;
  logic                   ovf_o;

  opentdc_event_fifo #(
    .DEPTH(DEPTH),
    .CW   (CW),
    .FW   (FW),
    .OVW  (OVW)
  ) dut (
    .wb_clk_i    (wb_clk_i),
    .rst_n_i     (rst_n_i),
    .evt_valid_i (evt_valid_i),
    .evt_coarse_i(evt_coarse_i),
    .evt_fine_i  (evt_fine_i),
    .rd_i        (rd_i),
    .clr_i       (clr_i),
    .rd_valid_o  (rd_valid_o),
    .rd_data_o   (rd_data_o),
    .level_o     (level_o),
    .full_o      (full_o),
    .ovf_cnt_o   (ovf_cnt_o),
    .ovf_o       (ovf_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  logic [DW-1:0] exp_q[$];
  int unsigned   m_ovf_cnt = 0;
  bit            m_ovf = 1'b0;
  int unsigned   n_checks = 0;
  int unsigned   n_pass = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    logic [DW-1:0] head;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("rd_valid", 64'(rd_valid_o), 64'(exp_q.size() > 0));
    check("level",    64'(level_o),    64'(exp_q.size()));
    check("full",     64'(full_o),     64'(exp_q.size() == DEPTH));
    check("rd_data",  64'(rd_data_o),  64'(head));
    check("ovf_cnt",  64'(ovf_cnt_o),  64'(m_ovf_cnt));
    check("ovf",      64'(ovf_o),      64'(m_ovf));
  endtask

  // Drive one cycle of stimulus; outputs are checked mid-cycle, then the model follows the edge.
  task automatic cycle(input bit v, input logic [CW-1:0] c, input logic [FW-1:0] f,
                       input bit rd, input bit clr, input bit rst_n);
    bit m_full, m_pop;
    evt_valid_i  = v;
    evt_coarse_i = c;
    evt_fine_i   = f;
    rd_i         = rd;
    clr_i        = clr;
    rst_n_i      = rst_n;
    @(negedge wb_clk_i);
    check_state();
    if (!rst_n || clr) begin
      exp_q.delete();
      m_ovf_cnt = 0;
      m_ovf     = 1'b0;
    end else begin
      m_full = (exp_q.size() == DEPTH);
      m_pop  = rd && (exp_q.size() > 0);
      if (m_pop) void'(exp_q.pop_front());
      if (v && (!m_full || m_pop)) exp_q.push_back({c, f});
      if (v && m_full && !m_pop) begin
        m_ovf = 1'b1;
        if (m_ovf_cnt < (1 << OVW) - 1) m_ovf_cnt++;
      end
    end
    @(posedge wb_clk_i);
    #1;
    evt_valid_i = 1'b0;
    rd_i        = 1'b0;
    clr_i       = 1'b0;
  endtask

  task automatic push(input logic [CW-1:0] c, input logic [FW-1:0] f);
    cycle(1'b1, c, f, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic pop();
    cycle(1'b0, '0, '0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle();
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    // Reset then idle
    rst_n_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    idle();
    check("rst_level", 64'(level_o), 64'd0);
    check("rst_data",  64'(rd_data_o), 64'd0);

    // Single event
    push(32'h0000_1234, 16'h00AB);
    check("single_data", 64'(rd_data_o), 64'h0000_1234_00AB);
    check("single_lvl",  64'(level_o), 64'd1);
    pop();
    idle();
    check("single_empty", 64'(rd_valid_o), 64'd0);

    // Fill and overflow
    for (int i = 1; i <= 10; i++) push(CW'(i), FW'(i * 3));
    idle();
    check("fill_level",  64'(level_o), 64'd8);
    check("fill_ovfcnt", 64'(ovf_cnt_o), 64'd2);
    check("fill_ovf",    64'(ovf_o), 64'd1);
    for (int i = 1; i <= 8; i++) begin
      check("fill_order", 64'(rd_data_o[DW-1:FW]), 64'(i));
      pop();
    end
    idle();

    // Wrap-around with offset push/pop pairs
    push(32'h100, 16'h1);
    for (int i = 1; i < 20; i++) begin
      cycle(1'b1, CW'(32'h100 + i), FW'(i + 1), 1'b1, 1'b0, 1'b1);
      check("wrap_lvl_le2", 64'(level_o <= 2), 64'd1);
    end
    pop();
    idle();

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) push(CW'(32'h200 + i), FW'(i));
    cycle(1'b1, 32'h0000_0099, 16'h0099, 1'b1, 1'b0, 1'b1);
    check("pp_level",  64'(level_o), 64'd8);
    check("pp_ovfcnt", 64'(ovf_cnt_o), 64'd2);
    check("pp_head",   64'(rd_data_o[DW-1:FW]), 64'h201);
    for (int i = 0; i < 7; i++) pop();
    check("pp_tail", 64'(rd_data_o), 64'h0000_0099_0099);
    pop();
    idle();

    // Saturation and clear
    for (int i = 0; i < 8; i++) push(CW'(32'h300 + i), FW'(i));
    for (int i = 0; i < 300; i++) push(CW'($urandom), FW'($urandom));
    idle();
    check("sat_ovfcnt", 64'(ovf_cnt_o), 64'd255);
    cycle(1'b1, 32'hDEAD_BEEF, 16'h5555, 1'b0, 1'b1, 1'b1);
    check("clr_level",  64'(level_o), 64'd0);
    check("clr_ovfcnt", 64'(ovf_cnt_o), 64'd0);
    check("clr_ovf",    64'(ovf_o), 64'd0);
    check("clr_valid",  64'(rd_valid_o), 64'd0);
    idle();

    // Reset while half full
    for (int i = 0; i < 4; i++) push(CW'(32'h400 + i), FW'(i));
    cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_mid_level", 64'(level_o), 64'd0);
    check("rst_mid_valid", 64'(rd_valid_o), 64'd0);
    idle();
    push(32'h0000_0555, 16'h0AAA);
    check("post_rst_data", 64'(rd_data_o), 64'h0000_0555_0AAA);
    pop();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/opentdc_event_fifo.md
Name: opentdc_event_fifo

Overview:
Timestamp buffer between the TDC channel capture logic and the wishbone register bank of the OpenTDC macro.
- Capture side: each TDC event (coarse cycle count plus fine delay-line code) is pushed into a first-word-fall-through FIFO.
- Bus side: the wishbone side reads events at its own pace.
- The capture side cannot be back-pressured. Events arriving while the FIFO is full are dropped and counted.

Parameters:
DEPTH, 8, number of FIFO entries; power of two, minimum 2.
CW, 32, coarse timestamp width (bits).
FW, 16, fine timestamp width (bits).
OVW, 8, overflow counter width (bits).

Ports:
wb_clk_i  input  1  single clock for the whole block (wishbone clock).
rst_n_i  input  1  reset, synchronous, active-low.
evt_valid_i  input  1  one-cycle strobe: capture an event this cycle.
evt_coarse_i  input  CW  coarse timestamp of the event.
evt_fine_i  input  FW  fine (delay-line) code of the event.
rd_i  input  1  one-cycle pop strobe from the register bank.
clr_i  input  1  flush FIFO and clear overflow state.
rd_valid_o  output  1  FIFO not empty; rd_data_o holds the oldest entry.
rd_data_o  output  CW+FW  oldest entry, layout {coarse, fine}.
level_o  output  log2(DEPTH)+1  current number of stored entries.
full_o  output  1  level_o == DEPTH.
ovf_cnt_o  output  OVW  number of dropped events, saturating.
ovf_o  output  1  sticky: at least one event dropped since reset/clear.

Behaviour:
- Reset:
  - All state is synchronous to the wb_clk_i rising edge while rst_n_i == 0.
  - Reset values: rd_valid_o=0, rd_data_o=0, level_o=0, full_o=0, ovf_cnt_o=0, ovf_o=0.
  - Read and write pointers are set to 0. Reset mid-stream discards every stored entry.
- Storage:
  - Circular buffer of DEPTH entries, each CW+FW bits wide.
  - Write pointer and read pointer are log2(DEPTH) bits and wrap modulo DEPTH.
  - Level is held in a separate counter of log2(DEPTH)+1 bits.
- Push: evt_valid_i=1 and not full, or full with a simultaneous pop.
  - {evt_coarse_i, evt_fine_i} is written at the write pointer and the pointer increments.
- Pop: rd_i=1 and level>0.
  - The read pointer increments.
  - rd_i while empty is ignored; no pointer change, no error flag.
- Level update per cycle:
  - push only: +1.
  - pop only: -1.
  - push and pop together: unchanged.
- Full with simultaneous push and pop: both are accepted, level stays DEPTH, nothing is dropped.
- Empty with simultaneous push and pop: the pop is ignored and the push is accepted; level becomes 1.
- Drop: evt_valid_i=1, full, and no pop in the same cycle.
  - The event is discarded and ovf_o is set to 1.
  - ovf_cnt_o increments and saturates at 2^OVW-1 (no wrap).
- Latency:
  - An event pushed in cycle N is visible on rd_data_o/rd_valid_o in cycle N+1.
  - rd_data_o is combinational from the storage entry at the read pointer.
  - After a pop in cycle N, the next entry (or rd_valid_o=0) is presented in cycle N+1.
- Empty output: rd_data_o is all-zero whenever rd_valid_o=0 (masked, so bus reads of an empty FIFO return 0).
- clr_i:
  - Priority over push and pop in the same cycle.
  - Next cycle: pointers=0, level=0, ovf_cnt_o=0, ovf_o=0.
  - An event presented in the same cycle as clr_i is lost and not counted as overflow.
- Status outputs:
  - full_o and rd_valid_o are derived from the level counter.
  - level_o, full_o and rd_valid_o are consistent in every cycle.
- Memory: storage contents are not reset. Only the pointers and counters are.

Test Plan:
- Reset then idle: hold rst_n_i=0 for 2 cycles, release -> rd_valid_o=0, level_o=0, full_o=0, ovf_cnt_o=0, rd_data_o=0.
- Single event: push coarse=0x00001234, fine=0x00AB -> next cycle rd_valid_o=1, rd_data_o=0x0000123400AB, level_o=1; pop -> next cycle rd_valid_o=0, level_o=0, rd_data_o=0.
- Fill and overflow: push 10 events with coarse=1..10 into DEPTH=8 -> full_o=1, level_o=8, ovf_cnt_o=2, ovf_o=1; 8 pops return coarse 1..8 in order.
- Wrap-around: run 20 push/pop pairs offset by one cycle -> data in strict order across pointer wrap; level never exceeds 2.
- Simultaneous push and pop when full: level stays 8, ovf_cnt_o unchanged, head advances by one, new entry appears at the tail 8 pops later.
- Saturation and clear:
  - Keep full and push 300 events with no pops -> ovf_cnt_o=255.
  - Assert clr_i together with evt_valid_i -> next cycle level_o=0, ovf_cnt_o=0, ovf_o=0, rd_valid_o=0.
  - Assert rst_n_i=0 while half full -> FIFO empties on the next edge.
